alu_result_dest_router: RTL and testbench

- Write-back end of the ALU datapath in the 16-bit multi-cycle core.
- Accepts one ALU result plus its flags from the control unit through a valid/ready handshake.
- Delivers the result to its selected destinations in sequence: register file, PSW flags, memory data write.
- Signals completion with a one-cycle done pulse.

---
 rtl/alu_result_dest_router.sv | 135 +++++++++++++
 tb/tb_alu_result_dest_router.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_result_dest_router.sv
// Write-back router for the ALU datapath: takes one result per handshake and
// delivers it to the register file, the PSW and memory, in that order, then pulses done.
module alu_result_dest_router #(
  parameter int WORD_SIZE  = 16,
  parameter int REG_ADDR_W = 3,
  parameter int PC_REG     = 7
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [WORD_SIZE-1:0]  result_in,
  input  logic [3:0]            flags_in,
  input  logic                  byte_op,
  input  logic                  reg_sel,
  input  logic                  psw_sel,
  input  logic                  mem_sel,
  input  logic [REG_ADDR_W-1:0] dst_reg,
  input  logic [WORD_SIZE-1:0]  reg_old_in,
  output logic                  reg_we,
  output logic [REG_ADDR_W-1:0] reg_waddr,
  output logic [WORD_SIZE-1:0]  reg_wdata,
  output logic                  pc_written,
  output logic                  psw_we,
  output logic [3:0]            psw_flags,
  output logic                  mem_req,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  output logic                  mem_byte,
  input  logic                  mem_ack,
  output logic                  done,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REG_WR = 2'd1;
  localparam logic [1:0] ST_MEM_WR = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [REG_ADDR_W-1:0] PC_ADDR = REG_ADDR_W'(PC_REG);

  logic [1:0]            state_reg, state_next;
  logic [WORD_SIZE-1:0]  result_reg;
  logic [WORD_SIZE-1:0]  old_reg;
  logic [3:0]            flags_reg;
  logic                  byte_reg;
  logic                  reg_sel_reg;
  logic                  psw_sel_reg;
  logic                  mem_sel_reg;
  logic [REG_ADDR_W-1:0] dst_reg_reg;
  logic                  psw_pend_reg;

  logic                  accept;
  logic [WORD_SIZE-1:0]  merged_word;
  logic [WORD_SIZE-1:0]  mem_word;

  assign accept = (state_reg == ST_IDLE) && res_valid;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (res_valid) begin
          if (reg_sel)      state_next = ST_REG_WR;
          else if (mem_sel) state_next = ST_MEM_WR;
          else              state_next = ST_DONE;
        end
      end
      ST_REG_WR: state_next = mem_sel_reg ? ST_MEM_WR : ST_DONE;
      ST_MEM_WR: if (mem_ack) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg    <= ST_IDLE;
      result_reg   <= '0;
      old_reg      <= '0;
      flags_reg    <= '0;
      byte_reg     <= 1'b0;
      reg_sel_reg  <= 1'b0;
      psw_sel_reg  <= 1'b0;
      mem_sel_reg  <= 1'b0;
      dst_reg_reg  <= '0;
      psw_pend_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      // The PSW strobe belongs to the first post-acceptance cycle regardless of route.
      psw_pend_reg <= accept && psw_sel;
      if (accept) begin
        result_reg  <= result_in;
        old_reg     <= reg_old_in;
        flags_reg   <= flags_in;
        byte_reg    <= byte_op;
        reg_sel_reg <= reg_sel;
        psw_sel_reg <= psw_sel;
        mem_sel_reg <= mem_sel;
        dst_reg_reg <= dst_reg;
      end
    end
  end

  // Low byte always comes from the result; upper bits either keep the old
  // register contents (register merge) or are zeroed (memory byte write).
  genvar gi;
  generate
    for (gi = 0; gi < WORD_SIZE; gi = gi + 1) begin : g_word
      if (gi < 8) begin : g_low
        assign merged_word[gi] = result_reg[gi];
        assign mem_word[gi]    = result_reg[gi];
      end else begin : g_high
        assign merged_word[gi] = byte_reg ? old_reg[gi] : result_reg[gi];
        assign mem_word[gi]    = byte_reg ? 1'b0 : result_reg[gi];
      end
    end
  endgenerate

  assign res_ready  = (state_reg == ST_IDLE);
  assign busy       = (state_reg != ST_IDLE);
  assign done       = (state_reg == ST_DONE);

  assign reg_we     = (state_reg == ST_REG_WR);
  assign reg_waddr  = reg_we ? dst_reg_reg : '0;
  assign reg_wdata  = reg_we ? merged_word : '0;
  assign pc_written = reg_we && (dst_reg_reg == PC_ADDR);

  assign psw_we     = psw_pend_reg && psw_sel_reg;
  assign psw_flags  = flags_reg;

  assign mem_req    = (state_reg == ST_MEM_WR);
  assign mem_wdata  = mem_req ? mem_word : '0;
  assign mem_byte   = mem_req && byte_reg;

endmodule

// File: tb/tb_alu_result_dest_router.sv
// Randomised and directed bench for alu_result_dest_router against a schedule-level model.
module tb_alu_result_dest_router;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] result_in;
  logic [3:0]  flags_in;
  logic        byte_op, reg_sel, psw_sel, mem_sel;
  logic [2:0]  dst_reg;
  logic [15:0] reg_old_in;
  logic        reg_we;
  logic [2:0]  reg_waddr;
  logic [15:0] reg_wdata;
  logic        pc_written, psw_we;
  logic [3:0]  psw_flags;
  logic        mem_req;
  logic [15:0] mem_wdata;
  logic        mem_byte, mem_ack, done, busy;

  int tests = 0;
  int fails = 0;
  int txn_no = 0;
  logic [3:0] cur_flags = 4'h0;

  always #5 clk = ~clk;

  alu_result_dest_router #(.WORD_SIZE(16), .REG_ADDR_W(3), .PC_REG(7)) dut (
    .clk(clk), .arst_n(arst_n), .res_valid(res_valid), .res_ready(res_ready),
    .result_in(result_in), .flags_in(flags_in), .byte_op(byte_op),
    .reg_sel(reg_sel), .psw_sel(psw_sel), .mem_sel(mem_sel), .dst_reg(dst_reg),
    .reg_old_in(reg_old_in), .reg_we(reg_we), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .pc_written(pc_written), .psw_we(psw_we),
    .psw_flags(psw_flags), .mem_req(mem_req), .mem_wdata(mem_wdata),
    .mem_byte(mem_byte), .mem_ack(mem_ack), .done(done), .busy(busy)
  );

  // Packed view: strobes, then address/data fields that matter only while their strobe is high.
  function automatic logic [46:0] mk(logic rw, logic pc, logic pw, logic mr, logic mb,
                                     logic dn, logic rdy, logic bsy, logic [2:0] wa,
                                     logic [15:0] wd, logic [15:0] md, logic [3:0] fl);
    return {rw, pc, pw, mr, mb, dn, rdy, bsy, wa, wd, md, fl};
  endfunction

  function automatic logic [46:0] observe();
    return mk(reg_we, pc_written, psw_we, mem_req, mem_req ? mem_byte : 1'b0, done,
              res_ready, busy, reg_we ? reg_waddr : 3'd0, reg_we ? reg_wdata : 16'd0,
              mem_req ? mem_wdata : 16'd0, psw_flags);
  endfunction

  task automatic check(input string tag, input logic [46:0] exp);
    logic [46:0] obs;
    obs = observe();
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    result_in  = 16'($urandom);
    flags_in   = 4'($urandom);
    byte_op    = 1'($urandom);
    reg_sel    = 1'($urandom);
    psw_sel    = 1'($urandom);
    mem_sel    = 1'($urandom);
    dst_reg    = 3'($urandom);
    reg_old_in = 16'($urandom);
  endtask

  // Called in an IDLE cycle (#1 after a rising edge); returns in the IDLE cycle after done.
  task automatic run_txn(input string name, input logic [15:0] res, input logic [3:0] fl,
                         input logic bo, input logic rs, input logic ps, input logic ms,
                         input logic [2:0] dst, input logic [15:0] old, input int ack_delay);
    int m0, kdone;
    logic [15:0] exp_rw, exp_mw;
    logic is_reg, is_mem, is_done;
    exp_rw = bo ? {old[15:8], res[7:0]} : res;
    exp_mw = bo ? {8'h00, res[7:0]} : res;
    m0     = rs ? 2 : 1;
    kdone  = ms ? m0 + ack_delay + 1 : m0;
    result_in = res; flags_in = fl; byte_op = bo; reg_sel = rs; psw_sel = ps;
    mem_sel = ms; dst_reg = dst; reg_old_in = old; res_valid = 1'b1;
    mem_ack = 1'($urandom);
    @(posedge clk); #1;
    cur_flags = fl;
    for (int k = 1; k <= kdone; k++) begin
      is_reg  = rs && (k == 1);
      is_mem  = ms && (k >= m0) && (k < kdone);
      is_done = (k == kdone);
      check($sformatf("%s k%0d", name, k),
            mk(is_reg, is_reg && (dst == 3'd7), ps && (k == 1), is_mem, is_mem && bo,
               is_done, 1'b0, 1'b1, is_reg ? dst : 3'd0, is_reg ? exp_rw : 16'd0,
               is_mem ? exp_mw : 16'd0, cur_flags));
      scramble();
      res_valid = is_done ? 1'b1 : 1'($urandom);
      mem_ack   = is_mem ? (k == m0 + ack_delay) : 1'($urandom);
      @(posedge clk); #1;
    end
    check($sformatf("%s idle", name),
          mk(0, 0, 0, 0, 0, 0, 1, 0, 3'd0, 16'd0, 16'd0, cur_flags));
    res_valid = 1'b0;
    mem_ack   = 1'b0;
    txn_no++;
    $display("[TB] txn %0d %s res=%h fl=%h byte=%0d sel=%0d%0d%0d dst=%0d ack_delay=%0d cycles=%0d",
             txn_no, name, res, fl, bo, rs, ps, ms, dst, ack_delay, kdone);
  endtask

  initial begin
    arst_n = 1'b0; res_valid = 1'b0; mem_ack = 1'b0;
    scramble();
    repeat (2) @(posedge clk);
    #1;
    check("reset", mk(0, 0, 0, 0, 0, 0, 1, 0, 3'd0, 16'd0, 16'd0, 4'h0));
    arst_n = 1'b1;
    @(posedge clk); #1;
    check("idle after reset", mk(0, 0, 0, 0, 0, 0, 1, 0, 3'd0, 16'd0, 16'd0, 4'h0));

    // Reset while a memory write is still waiting for its ack.
    result_in = 16'h5A5A; flags_in = 4'hA; byte_op = 1'b0; reg_sel = 1'b0;
    psw_sel = 1'b1; mem_sel = 1'b1; dst_reg = 3'd2; reg_old_in = 16'h0;
    res_valid = 1'b1; mem_ack = 1'b0;
    @(posedge clk); #1;
    res_valid = 1'b0;
    check("rst mem k1", mk(0, 0, 1, 1, 0, 0, 0, 1, 3'd0, 16'd0, 16'h5A5A, 4'hA));
    @(posedge clk); #1;
    check("rst mem k2", mk(0, 0, 0, 1, 0, 0, 0, 1, 3'd0, 16'd0, 16'h5A5A, 4'hA));
    arst_n = 1'b0;
    #1;
    check("rst mid mem", mk(0, 0, 0, 0, 0, 0, 1, 0, 3'd0, 16'd0, 16'd0, 4'h0));
    @(posedge clk); #1;
    arst_n = 1'b1;
    cur_flags = 4'h0;
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'($urandom);
      @(posedge clk); #1;
      check($sformatf("post rst idle %0d", i),
            mk(0, 0, 0, 0, 0, 0, 1, 0, 3'd0, 16'd0, 16'd0, 4'h0));
    end
    mem_ack = 1'b0;

    run_txn("word_reg",  16'hBEEF, 4'h0,    0, 1, 0, 0, 3'd3, 16'h1234, 0);
    run_txn("byte_psw",  16'h12AB, 4'b0100, 1, 1, 1, 0, 3'd1, 16'h7700, 0);
    run_txn("pc_write",  16'h0400, 4'h3,    0, 1, 0, 0, 3'd7, 16'hFFFF, 0);
    run_txn("reg_mem",   16'h00C3, 4'h0,    1, 1, 0, 1, 3'd5, 16'hAAAA, 3);
    run_txn("none",      16'hDEAD, 4'hF,    0, 0, 0, 0, 3'd0, 16'h0,    0);
    run_txn("mem_imm",   16'hFF81, 4'h9,    1, 0, 1, 1, 3'd4, 16'h0,    0);
    run_txn("all_imm",   16'h8001, 4'h6,    0, 1, 1, 1, 3'd7, 16'h0,    0);
    run_txn("psw_only",  16'h0000, 4'hC,    0, 0, 1, 0, 3'd6, 16'h0,    0);

    for (int i = 0; i < 120; i++) begin
      run_txn("rand", 16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 3'($urandom), 16'($urandom),
              int'($urandom_range(0, 4)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
